// File: rtl/i2c_slave_sync.sv
`timescale 1ns/1ps
// i2c_slave_sync
// Fully clocked I2C target. SCL and SDA are oversampled with the system
// clock, synchronized, and debounced. START and STOP are then detected on
// the clean levels, and a byte-level FSM matches a 7-bit address, ACKs it,
// and moves data between the bus and local logic.
//
// Ports
//   clk      system clock, at least 20x the SCL frequency
//   rst      asynchronous active-high reset
//   addr_in  7-bit address this target answers to
//   scl      I2C clock line (input only, no clock stretching)
//   sda      I2C data line, open-drain: driven to 0 or released to 'z'
//   tx_data  byte to send on a read, captured while tx_req is high
//   rx_data  last byte written by the master
//   rx_valid one-cycle pulse when rx_data has just been updated
//   tx_req   one-cycle pulse while tx_data is being captured
//   busy     high from an addressed START until STOP
//   rw_dir   R/W bit of the current addressed transfer (1 = read)
module i2c_slave_sync #(
  parameter int FILTER_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr_in,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       rw_dir
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } state_t;

  // A level is accepted once the synchronized input has disagreed with the
  // filtered level for FILTER_LEN consecutive samples.
  localparam logic [1:0] FLT_MAX = 2'(FILTER_LEN - 1);

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] filt;
  logic [1:0] filt_d;
  logic [1:0] flt_cnt [2];

  logic scl_f;
  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_nxt;
  logic [6:0] rx_shift;
  logic [6:0] rx_shift_nxt;
  logic [6:0] tx_shift;
  logic [6:0] tx_shift_nxt;
  logic       sda_oe;
  logic       sda_oe_nxt;
  logic [7:0] rx_data_nxt;
  logic       rx_valid_nxt;
  logic       busy_nxt;
  logic       rw_dir_nxt;

  // Open-drain output: only ever pull low or let go.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizer followed by a run-length stability filter.
  // Everything resets to 1, the idle level of both bus lines, so a
  // reset never manufactures a START or STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a     <= 2'b11;
      sync_b     <= 2'b11;
      filt       <= 2'b11;
      filt_d     <= 2'b11;
      flt_cnt[0] <= 2'd0;
      flt_cnt[1] <= 2'd0;
    end else begin
      sync_a <= {sda, scl};
      sync_b <= sync_a;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          flt_cnt[i] <= 2'd0;
        end else if (flt_cnt[i] == FLT_MAX) begin
          filt[i]    <= sync_b[i];
          flt_cnt[i] <= 2'd0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 2'd1;
        end
      end
    end
  end

  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_rise  = filt[0] & ~filt_d[0];
  assign scl_fall  = ~filt[0] & filt_d[0];
  // SDA moving while SCL is high is a bus condition, not data.
  assign start_det = scl_f & filt_d[1] & ~sda_f;
  assign stop_det  = scl_f & ~filt_d[1] & sda_f;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers that follow the FSM decisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 7'h7f;
      sda_oe   <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      rw_dir   <= 1'b0;
    end else begin
      bit_cnt  <= bit_cnt_nxt;
      rx_shift <= rx_shift_nxt;
      tx_shift <= tx_shift_nxt;
      sda_oe   <= sda_oe_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      busy     <= busy_nxt;
      rw_dir   <= rw_dir_nxt;
    end
  end

  // Next-state and output logic. Inside the ACK states sda_oe doubles as
  // the phase marker: the first scl_fall starts pulling low, the second
  // one ends the ACK window. tx_shift holds only the bits still to send,
  // bit 7 being driven straight from tx_data when it is captured.
  // START/STOP are applied last so they override whatever the state did,
  // while an rx_valid raised in the same cycle is kept.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    rx_shift_nxt = rx_shift;
    tx_shift_nxt = tx_shift;
    sda_oe_nxt   = sda_oe;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    busy_nxt     = busy;
    rw_dir_nxt   = rw_dir;
    tx_req       = 1'b0;

    case (state)
      IDLE, WAIT_STOP: begin
        sda_oe_nxt = 1'b0;
      end

      ADDR: begin
        if (scl_rise) begin
          rx_shift_nxt = {rx_shift[5:0], sda_f};
          bit_cnt_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_shift == addr_in) begin
              state_nxt  = ADDR_ACK;
              rw_dir_nxt = sda_f;
              busy_nxt   = 1'b1;
            end else begin
              state_nxt  = WAIT_STOP;
              busy_nxt   = 1'b0;
            end
          end
        end
      end

      ADDR_ACK: begin
        if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_nxt = 1'b1;
          end else if (rw_dir) begin
            tx_req       = 1'b1;
            tx_shift_nxt = tx_data[6:0];
            sda_oe_nxt   = ~tx_data[7];
            bit_cnt_nxt  = 3'd0;
            state_nxt    = READ;
          end else begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = WRITE;
          end
        end
      end

      WRITE: begin
        if (scl_rise) begin
          rx_shift_nxt = {rx_shift[5:0], sda_f};
          bit_cnt_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_nxt  = {rx_shift, sda_f};
            rx_valid_nxt = 1'b1;
            state_nxt    = WRITE_ACK;
          end
        end
      end

      WRITE_ACK: begin
        if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_nxt = 1'b1;
          end else begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = WRITE;
          end
        end
      end

      READ: begin
        // bit_cnt counts scl falls; the eighth one ends bit 0.
        if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            sda_oe_nxt = 1'b0;
            state_nxt  = READ_ACK;
          end else begin
            sda_oe_nxt   = ~tx_shift[6];
            tx_shift_nxt = {tx_shift[5:0], 1'b1};
            bit_cnt_nxt  = bit_cnt + 3'd1;
          end
        end
      end

      READ_ACK: begin
        if (scl_rise && sda_f) begin
          state_nxt = WAIT_STOP;
        end else if (scl_fall) begin
          tx_req       = 1'b1;
          tx_shift_nxt = tx_data[6:0];
          sda_oe_nxt   = ~tx_data[7];
          bit_cnt_nxt  = 3'd0;
          state_nxt    = READ;
        end
      end

      default: begin
        state_nxt  = IDLE;
        sda_oe_nxt = 1'b0;
      end
    endcase

    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 3'd0;
      sda_oe_nxt  = 1'b0;
    end
    if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_slave_sync.sv
`timescale 1ns/1ps
// tb_i2c_slave_sync
// Directed bench acting as the I2C controller. The bench bit-bangs SCL and
// an open-drain SDA with a pull-up, and checks the target against
// hand-computed values.
module tb_i2c_slave_sync;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] addr_in;
  logic       scl;
  logic       sda_low;
  logic [7:0] tx_data;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic       rw_dir;

  int checks = 0;
  int passed = 0;

  logic [7:0] rx_log[$];
  int tx_req_cnt = 0;
  int dut_pull_cnt = 0;
  int both_cnt = 0;
  int busy_low_cnt = 0;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_sync #(.FILTER_LEN(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr_in  (addr_in),
    .scl      (scl),
    .sda      (sda),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .busy     (busy),
    .rw_dir   (rw_dir)
  );

  // Observe pulses and bus activity away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (tx_req) tx_req_cnt++;
    if (rx_valid && tx_req) both_cnt++;
    if (!sda_low && sda === 1'b0) dut_pull_cnt++;
    if (!busy) busy_low_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(Q); sda_low = 1'b1; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic bus_rstart();
    wait_clk(Q); sda_low = 1'b0; wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_low = 1'b1; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q); sda_low = 1'b1; wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_low = 1'b0; wait_clk(Q);
  endtask

  // One SCL period starting and ending with SCL low; s is the bus level
  // seen in the middle of the high phase.
  task automatic bus_bit(input logic b, output logic s);
    wait_clk(Q); sda_low = ~b; wait_clk(Q); scl = 1'b1;
    wait_clk(Q); s = sda; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
      if (i == 7) tx_data = next_tx;
    end
    bus_bit(nack, s);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; sda_low = 1'b0; addr_in = 7'h2A; tx_data = 8'h00;
    wait_clk(5);
    checks++; if (sda !== 1'b1) $display("[TB] FAIL reset_sda: got %b want 1", sda); else passed++;
    checks++; if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
    checks++; if ({rx_valid, tx_req, busy, rw_dir} !== 4'b0000) $display("[TB] FAIL reset_flags: got %b want 0000", {rx_valid, tx_req, busy, rw_dir}); else passed++;
    rst = 1'b0;
    wait_clk(Q);
  endtask

  task automatic test_write();
    logic ack;
    int n0;
    n0 = rx_log.size();
    bus_start();
    write_byte(8'h54, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL write_addr_ack: got %b want 1", ack); else passed++;
    write_byte(8'h3C, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL write_d0_ack: got %b want 1", ack); else passed++;
    write_byte(8'hF0, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL write_d1_ack: got %b want 1", ack); else passed++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL write_busy: got %b want 1", busy); else passed++;
    checks++; if (rw_dir !== 1'b0) $display("[TB] FAIL write_rw_dir: got %b want 0", rw_dir); else passed++;
    bus_stop();
    wait_clk(Q);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL write_busy_stop: got %b want 0", busy); else passed++;
    checks++; if (rx_log.size() - n0 !== 2) $display("[TB] FAIL write_rx_count: got %0d want 2", rx_log.size() - n0); else passed++;
    if (rx_log.size() - n0 == 2) begin
      checks++; if (rx_log[n0] !== 8'h3C) $display("[TB] FAIL write_rx0: got %h want 3c", rx_log[n0]); else passed++;
      checks++; if (rx_log[n0 + 1] !== 8'hF0) $display("[TB] FAIL write_rx1: got %h want f0", rx_log[n0 + 1]); else passed++;
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    int n0, p0;
    n0 = rx_log.size(); p0 = dut_pull_cnt;
    bus_start();
    write_byte(8'h56, ack);
    checks++; if (ack !== 1'b0) $display("[TB] FAIL mismatch_addr_nack: got ack %b want 0", ack); else passed++;
    write_byte(8'h11, ack);
    checks++; if (ack !== 1'b0) $display("[TB] FAIL mismatch_data_nack: got ack %b want 0", ack); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL mismatch_busy: got %b want 0", busy); else passed++;
    bus_stop();
    wait_clk(Q);
    checks++; if (dut_pull_cnt != p0) $display("[TB] FAIL mismatch_sda_pull: got %0d cycles want 0", dut_pull_cnt - p0); else passed++;
    checks++; if (rx_log.size() != n0) $display("[TB] FAIL mismatch_rx_valid: got %0d want 0", rx_log.size() - n0); else passed++;
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int t0;
    t0 = tx_req_cnt;
    tx_data = 8'hA5;
    bus_start();
    write_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL read_addr_ack: got %b want 1", ack); else passed++;
    checks++; if (rw_dir !== 1'b1) $display("[TB] FAIL read_rw_dir: got %b want 1", rw_dir); else passed++;
    read_byte(1'b0, 8'h5A, d);
    checks++; if (d !== 8'hA5) $display("[TB] FAIL read_byte0: got %h want a5", d); else passed++;
    read_byte(1'b1, 8'h00, d);
    checks++; if (d !== 8'h5A) $display("[TB] FAIL read_byte1: got %h want 5a", d); else passed++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL read_busy: got %b want 1", busy); else passed++;
    bus_stop();
    wait_clk(Q);
    checks++; if (tx_req_cnt - t0 != 2) $display("[TB] FAIL read_tx_req_count: got %0d want 2", tx_req_cnt - t0); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL read_busy_stop: got %b want 0", busy); else passed++;
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] d;
    int n0, b0;
    n0 = rx_log.size();
    bus_start();
    write_byte(8'h54, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL rs_waddr_ack: got %b want 1", ack); else passed++;
    b0 = busy_low_cnt;
    write_byte(8'h07, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL rs_wdata_ack: got %b want 1", ack); else passed++;
    tx_data = 8'hC3;
    bus_rstart();
    write_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL rs_raddr_ack: got %b want 1", ack); else passed++;
    checks++; if (rw_dir !== 1'b1) $display("[TB] FAIL rs_rw_dir: got %b want 1", rw_dir); else passed++;
    read_byte(1'b1, 8'h00, d);
    checks++; if (d !== 8'hC3) $display("[TB] FAIL rs_read: got %h want c3", d); else passed++;
    checks++; if (busy_low_cnt != b0) $display("[TB] FAIL rs_busy_held: got %0d low cycles want 0", busy_low_cnt - b0); else passed++;
    checks++; if (rx_log.size() - n0 !== 1 || rx_data !== 8'h07) $display("[TB] FAIL rs_rx: got %0d bytes last %h want 1 bytes last 07", rx_log.size() - n0, rx_data); else passed++;
    bus_stop();
    wait_clk(Q);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rs_busy_stop: got %b want 0", busy); else passed++;
  endtask

  task automatic test_glitch();
    logic ack;
    int n0;
    n0 = rx_log.size();
    scl = 1'b0; wait_clk(1); scl = 1'b1;
    wait_clk(Q);
    checks++; if (busy !== 1'b0 || rx_log.size() != n0) $display("[TB] FAIL glitch_idle: got busy %b rx %0d want busy 0 rx 0", busy, rx_log.size() - n0); else passed++;
    wait_clk(Q); sda_low = 1'b1; wait_clk(Q);
    scl = 1'b0; wait_clk(1); scl = 1'b1;
    wait_clk(Q); scl = 1'b0;
    write_byte(8'h54, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL glitch_addr_ack: got %b want 1", ack); else passed++;
    write_byte(8'h99, ack);
    bus_stop();
    wait_clk(Q);
    checks++; if (rx_data !== 8'h99 || rx_log.size() - n0 != 1) $display("[TB] FAIL glitch_rx: got %h (%0d bytes) want 99 (1 byte)", rx_data, rx_log.size() - n0); else passed++;
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    logic [7:0] d;
    logic s;
    tx_data = 8'hA5;
    bus_start();
    write_byte(8'h55, ack);
    d = 8'h00;
    for (int i = 7; i >= 4; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    checks++; if (d[7:4] !== 4'hA) $display("[TB] FAIL rmr_high_nibble: got %h want a", d[7:4]); else passed++;
    wait_clk(Q);
    checks++; if (sda !== 1'b0) $display("[TB] FAIL rmr_bit3_driven: got %b want 0", sda); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (sda !== 1'b1) $display("[TB] FAIL rmr_sda_release: got %b want 1", sda); else passed++;
    checks++; if ({rx_data, rx_valid, tx_req, busy, rw_dir} !== 12'h000) $display("[TB] FAIL rmr_outputs: got %h want 000", {rx_data, rx_valid, tx_req, busy, rw_dir}); else passed++;
    wait_clk(3);
    rst = 1'b0;
    scl = 1'b1;
    wait_clk(2 * Q);
    bus_start();
    write_byte(8'h54, ack);
    checks++; if (ack !== 1'b1) $display("[TB] FAIL rmr_next_ack: got %b want 1", ack); else passed++;
    write_byte(8'h66, ack);
    bus_stop();
    wait_clk(Q);
    checks++; if (rx_data !== 8'h66) $display("[TB] FAIL rmr_next_rx: got %h want 66", rx_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_repeated_start();
    test_glitch();
    test_reset_mid_read();
    checks++; if (both_cnt != 0) $display("[TB] FAIL pulse_overlap: got %0d cycles want 0", both_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
